gelu_cubic_arbiter: RTL and testbench

- Round-robin arbiter that shares one x^3 pipeline (2-multiply, fixed latency) among NUM_REQ GELU lanes.
- Tracks a requester tag alongside each issued operand and routes each result back to its lane.
- Each lane has a one-entry result buffer with valid/ready handshake.
- Sits between the per-lane GELU polynomial front-ends and the single shared cubic calculator instance.

---
 rtl/gelu_cubic_arbiter.sv | 144 ++++++++++++++
 tb/tb_gelu_cubic_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelu_cubic_arbiter.sv
// Round-robin arbiter sharing one fixed-latency x^3 pipeline among NUM_REQ GELU lanes,
// with per-lane one-entry result buffers. Define GELU_CUBIC_SAT_EN to saturate overflowed results.
module gelu_cubic_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 24,
  parameter int FRAC_BITS  = 16,
  parameter int PIPE_LAT   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic [NUM_REQ-1:0]            rsp_overflow,
  output logic [DATA_WIDTH-1:0]         cube_x,
  output logic                          cube_valid_in,
  input  logic [DATA_WIDTH-1:0]         cube_result,
  input  logic                          cube_valid_out,
  input  logic                          cube_overflow,
  output logic                          busy,
  output logic                          protocol_err
);
  localparam int LW = $clog2(NUM_REQ);

  logic [LW-1:0]                 r_rr_ptr;
  logic [NUM_REQ-1:0]            r_inflight;
  logic [NUM_REQ-1:0]            r_rsp_valid;
  logic [NUM_REQ-1:0]            r_rsp_ovf;
  logic [NUM_REQ*DATA_WIDTH-1:0] r_rsp_data;
  logic                          r_err;
  logic [PIPE_LAT-1:0]           r_tag_vld;
  logic [LW-1:0]                 r_tag_id [PIPE_LAT];
`ifdef GELU_CUBIC_SAT_EN
  logic [PIPE_LAT-1:0]           r_tag_sgn;
`endif

  logic [NUM_REQ-1:0]    w_elig;
  logic                  w_grant_vld;
  logic [LW-1:0]         w_grant_id;
  logic [LW-1:0]         w_next_ptr;
  logic [DATA_WIDTH-1:0] w_grant_op;
  logic                  w_head_vld;
  logic [LW-1:0]         w_head_id;
  logic [DATA_WIDTH-1:0] w_cap_data;

  // A lane whose buffer is being drained this cycle may reissue immediately.
  assign w_elig = ~{NUM_REQ{rst}} & req_valid & ~r_inflight & (~r_rsp_valid | rsp_ready);

  always_comb begin
    int            idx;
    logic [LW-1:0] sel;
    idx         = 0;
    sel         = '0;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    // Walk from the farthest offset down so the nearest eligible lane wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = LW'(idx);
      if (w_elig[sel]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = sel;
      end
    end
  end

  assign w_next_ptr = (w_grant_id == LW'(NUM_REQ - 1)) ? '0 : w_grant_id + LW'(1);
  assign w_grant_op = req_data[w_grant_id*DATA_WIDTH +: DATA_WIDTH];

  assign req_ready     = w_grant_vld ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign cube_valid_in = w_grant_vld;
  assign cube_x        = w_grant_vld ? w_grant_op : '0;

  assign w_head_vld = r_tag_vld[PIPE_LAT-1];
  assign w_head_id  = r_tag_id[PIPE_LAT-1];

`ifdef GELU_CUBIC_SAT_EN
  localparam int INT_BITS = DATA_WIDTH - FRAC_BITS;
  localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(INT_BITS-1){1'b1}}, {FRAC_BITS{1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_NEG = ~SAT_POS;
  assign w_cap_data = !cube_overflow ? cube_result :
                      (r_tag_sgn[PIPE_LAT-1] ? SAT_NEG : SAT_POS);
`else
  assign w_cap_data = cube_result;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_inflight  <= '0;
      r_rsp_valid <= '0;
      r_rsp_ovf   <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
      r_tag_vld   <= '0;
      for (int s = 0; s < PIPE_LAT; s++) r_tag_id[s] <= '0;
`ifdef GELU_CUBIC_SAT_EN
      r_tag_sgn   <= '0;
`endif
    end else begin
      r_tag_vld[0] <= w_grant_vld;
      r_tag_id[0]  <= w_grant_id;
`ifdef GELU_CUBIC_SAT_EN
      r_tag_sgn[0] <= w_grant_op[DATA_WIDTH-1];
`endif
      for (int s = 1; s < PIPE_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
`ifdef GELU_CUBIC_SAT_EN
        r_tag_sgn[s] <= r_tag_sgn[s-1];
`endif
      end

      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_rsp_valid[i] && rsp_ready[i]) r_rsp_valid[i] <= 1'b0;
      end

      // A tag at the head retires its lane whether or not the result showed up.
      if (w_head_vld) r_inflight[w_head_id] <= 1'b0;
      if (w_head_vld && cube_valid_out) begin
        r_rsp_valid[w_head_id]                       <= 1'b1;
        r_rsp_ovf[w_head_id]                         <= cube_overflow;
        r_rsp_data[w_head_id*DATA_WIDTH +: DATA_WIDTH] <= w_cap_data;
      end
      if (w_head_vld ^ cube_valid_out) r_err <= 1'b1;

      if (w_grant_vld) begin
        r_inflight[w_grant_id] <= 1'b1;
        r_rr_ptr               <= w_next_ptr;
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_overflow = r_rsp_ovf;
  assign busy         = (|r_inflight) | (|r_rsp_valid);
  assign protocol_err = r_err;

endmodule

// File: tb/tb_gelu_cubic_arbiter.sv
// Bench for gelu_cubic_arbiter: emulates the shared cube pipeline and checks against a
// transaction-level model of the arbiter (round-robin grants, pending-result queue, lane buffers).
module tb_gelu_cubic_arbiter;
  localparam int N  = 4;
  localparam int DW = 24;
  localparam int PL = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready, rsp_overflow;
  logic [N*DW-1:0] req_data, rsp_data;
  logic [DW-1:0]   cube_x, cube_result;
  logic            cube_valid_in, cube_valid_out, cube_overflow, busy, protocol_err;

  gelu_cubic_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .FRAC_BITS(16), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_overflow(rsp_overflow),
    .cube_x(cube_x), .cube_valid_in(cube_valid_in), .cube_result(cube_result),
    .cube_valid_out(cube_valid_out), .cube_overflow(cube_overflow),
    .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [DW-1:0] x; } op_t;
  typedef struct { int due; int lane; logic sgn; } tag_t;

  op_t  rq[$];
  tag_t mq[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic          tb_rst, inj_stray, inj_drop;
  logic [N-1:0]  tb_rv, tb_rr;
  logic [DW-1:0] tb_data [N];

  logic          m_live;
  int            m_ptr;
  logic [N-1:0]  m_infl, m_rv, m_ro;
  logic [DW-1:0] m_rd [N];
  logic          m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Q8.16 cube: full product, drop 32 fraction bits, flag results outside 24-bit signed range.
  function automatic logic [DW:0] cube(input logic [DW-1:0] x);
    logic signed [79:0] xs, p, q;
    logic ovf;
    xs  = {{56{x[DW-1]}}, x};
    p   = xs * xs * xs;
    q   = p >>> 32;
    ovf = (q > 80'sd8388607) || (q < -80'sd8388608);
    return {ovf, q[DW-1:0]};
  endfunction

  function automatic logic [DW-1:0] rnd_op();
    logic [DW-1:0] v;
    if ($urandom_range(0, 7) == 0) v = DW'($urandom);
    else v = DW'($urandom_range(0, 24'h80000)) - 24'h040000;
    return v;
  endfunction

  task automatic run_cycle();
    logic [DW:0]   cr;
    logic [DW-1:0] cres, exp_x, cap;
    logic          cvo, covf;
    logic [N-1:0]  exp_rdy;
    int            g, cl;
    op_t           op;
    tag_t          t;

    rst = tb_rst; req_valid = tb_rv; rsp_ready = tb_rr;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = tb_data[i];
    cvo = 1'b0; cres = '0; covf = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      op   = rq.pop_front();
      cr   = cube(op.x);
      cvo  = !inj_drop;
      cres = cr[DW-1:0];
      covf = cr[DW];
    end
    if (inj_stray && !cvo) begin
      cvo = 1'b1; cres = DW'($urandom); covf = 1'b0;
    end
    cube_valid_out = cvo; cube_result = cres; cube_overflow = covf;
    #4;

    g = -1;
    if (!tb_rst) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && tb_rv[j] && !m_infl[j] && (!m_rv[j] || tb_rr[j])) g = j;
      end
    end
    exp_rdy = (g >= 0) ? N'(1) << g : '0;
    exp_x   = (g >= 0) ? tb_data[g] : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("cube_valid_in", 64'(cube_valid_in), 64'(g >= 0));
    chk("cube_x", 64'(cube_x), 64'(exp_x));
    if (m_live) begin
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
      chk("rsp_overflow", 64'(rsp_overflow), 64'(m_ro));
      for (int i = 0; i < N; i++)
        chk($sformatf("rsp_data%0d", i), 64'(rsp_data[i*DW +: DW]), 64'(m_rd[i]));
      chk("busy", 64'(busy), 64'((|m_infl) | (|m_rv)));
      chk("protocol_err", 64'(protocol_err), 64'(m_err));
    end

    if (cube_valid_in === 1'b1) rq.push_back('{due: cyc + PL, x: cube_x});

    if (tb_rst) begin
      m_live = 1'b1; m_ptr = 0; m_infl = '0; m_rv = '0; m_ro = '0; m_err = 1'b0;
      for (int i = 0; i < N; i++) m_rd[i] = '0;
      mq.delete();
    end else begin
      cl = -1;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        t = mq.pop_front();
        m_infl[t.lane] = 1'b0;
        if (cvo) begin
          cl  = t.lane;
          cap = cres;
`ifdef GELU_CUBIC_SAT_EN
          if (covf) cap = t.sgn ? 24'h800000 : 24'h7FFFFF;
`endif
          m_rv[cl] = 1'b1; m_ro[cl] = covf; m_rd[cl] = cap;
        end else m_err = 1'b1;
      end else if (cvo) m_err = 1'b1;
      for (int i = 0; i < N; i++)
        if (i != cl && m_rv[i] && tb_rr[i]) m_rv[i] = 1'b0;
      if (g >= 0) begin
        m_infl[g] = 1'b1;
        m_ptr     = (g + 1) % N;
        mq.push_back('{due: cyc + PL, lane: g, sgn: tb_data[g][DW-1]});
      end
    end

    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    tb_rv = '0;
    repeat (n) run_cycle();
  endtask

  // Issue one op on a lane, wait out the pipeline, check the landed result directly.
  task automatic single_op(input int lane, input logic [DW-1:0] x,
                           input logic [DW-1:0] exp_d, input logic exp_o);
    tb_rv = N'(1) << lane;
    tb_data[lane] = x;
    run_cycle();
    idle(PL);
    chk($sformatf("single_vld%0d", lane), 64'(rsp_valid[lane]), 64'(1));
    chk($sformatf("single_dat%0d", lane), 64'(rsp_data[lane*DW +: DW]), 64'(exp_d));
    chk($sformatf("single_ovf%0d", lane), 64'(rsp_overflow[lane]), 64'(exp_o));
  endtask

  initial begin
    tb_rst = 1'b1; inj_stray = 1'b0; inj_drop = 1'b0;
    tb_rv = '0; tb_rr = '1; m_live = 1'b0;
    m_ptr = 0; m_infl = '0; m_rv = '0; m_ro = '0; m_err = 1'b0;
    for (int i = 0; i < N; i++) begin tb_data[i] = '0; m_rd[i] = '0; end
    rst = 1'b1; req_valid = '0; rsp_ready = '1; req_data = '0;
    cube_valid_out = 1'b0; cube_result = '0; cube_overflow = 1'b0;
    @(posedge clk); #1;

    run_cycle(); run_cycle();
    tb_rst = 1'b0;
    idle(2);

    single_op(0, 24'h020000, 24'h080000, 1'b0);
    single_op(2, 24'hFE8000, 24'hFCA000, 1'b0);

    // All lanes streaming; lane 2 carries -1.5.
    tb_rv = '1; tb_rr = '1;
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < N; i++) tb_data[i] = (i == 2) ? 24'hFE8000 : rnd_op();
      run_cycle();
    end

    // Lane 1 result held un-consumed.
    tb_rr = 4'b1101;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) tb_data[i] = rnd_op();
      run_cycle();
    end
    tb_rr = '1;
    idle(PL + 2);

`ifdef GELU_CUBIC_SAT_EN
    single_op(0, 24'h7F0000, 24'h7FFFFF, 1'b1);
    single_op(1, 24'h810000, 24'h800000, 1'b1);
`else
    single_op(0, 24'h7F0000, cube(24'h7F0000), 1'b1);
    single_op(1, 24'h810000, cube(24'h810000), 1'b1);
`endif

    for (int c = 0; c < 400; c++) begin
      tb_rv = N'($urandom); tb_rr = N'($urandom);
      for (int i = 0; i < N; i++) tb_data[i] = rnd_op();
      run_cycle();
    end
    tb_rr = '1;
    idle(PL + 2);

    // Reset with ops in flight; their results arrive untagged afterwards.
    tb_rv = '1;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) tb_data[i] = rnd_op();
      run_cycle();
    end
    tb_rst = 1'b1; tb_rv = '0;
    run_cycle();
    tb_rst = 1'b0;
    chk("post_rst_valid", 64'(rsp_valid), 64'(0));
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_err", 64'(protocol_err), 64'(0));
    chk("post_rst_ready", 64'(req_ready), 64'(0));
    idle(PL + 1);
    chk("stray_after_rst_err", 64'(protocol_err), 64'(1));

    // Stray result with an empty tag pipe while lane 3 holds a result.
    tb_rst = 1'b1; run_cycle(); tb_rst = 1'b0;
    tb_rr = 4'b0111;
    single_op(3, 24'h018000, cube(24'h018000), 1'b0);
    inj_stray = 1'b1; idle(1); inj_stray = 1'b0;
    idle(1);
    chk("stray_err", 64'(protocol_err), 64'(1));
    chk("stray_keep_vld", 64'(rsp_valid), 64'(4'b1000));
    chk("stray_keep_dat", 64'(rsp_data[3*DW +: DW]), 64'(cube(24'h018000)));
    tb_rr = '1;
    idle(2);

    // Tag with no result: lane retires silently.
    tb_rst = 1'b1; run_cycle(); tb_rst = 1'b0;
    tb_rv = 4'b0001; tb_data[0] = 24'h010000;
    run_cycle();
    idle(PL - 1);
    inj_drop = 1'b1; idle(1); inj_drop = 1'b0;
    chk("drop_err", 64'(protocol_err), 64'(1));
    chk("drop_busy", 64'(busy), 64'(0));
    chk("drop_vld", 64'(rsp_valid), 64'(0));
    single_op(0, 24'h010000, 24'h010000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
